// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter with bounded lock bursts in front of a single-port
// memory whose read data returns two cycles after the read address is presented.
module mem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c0_req,
  input  logic              c1_req,
  input  logic              c0_we,
  input  logic              c1_we,
  input  logic              c0_lock,
  input  logic              c1_lock,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c0_gnt,
  output logic              c1_gnt,
  output logic              c0_rvalid,
  output logic              c1_rvalid,
  output logic [DATA_W-1:0] c0_rdata,
  output logic [DATA_W-1:0] c1_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata
);

  localparam int               CNT_W   = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

  logic              last_q, last_d;
  logic              owner_q, owner_d;
  logic              lock_q, lock_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  tag_t              tag1_q, tag1_d, tag2_q;

  logic              any_req, grant, win, win_we, win_lock, rd_grant;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // lock_q means the previous cycle was a locked grant to owner_q.
  always_comb begin
    // NOTE: default assignment first so every path drives win and no latch is inferred.
    win = ~last_q;
    if (c0_req && !c1_req)                 win = 1'b0;
    else if (c1_req && !c0_req)            win = 1'b1;
    else if (lock_q && (cnt_q < MAX_CNT))  win = owner_q;
  end

  assign any_req   = c0_req | c1_req;
  assign grant     = any_req & ~reset;
  assign win_we    = win ? c1_we    : c0_we;
  assign win_lock  = win ? c1_lock  : c0_lock;
  assign win_addr  = win ? c1_addr  : c0_addr;
  assign win_wdata = win ? c1_wdata : c0_wdata;

  assign c0_gnt    = grant & ~win;
  assign c1_gnt    = grant &  win;
  assign mem_we    = grant & win_we;
  assign mem_waddr = mem_we ? win_addr  : '0;
  assign mem_wdata = mem_we ? win_wdata : '0;
  assign rd_grant  = grant & ~win_we;
  assign mem_raddr = rd_grant ? win_addr : raddr_q;

  always_comb begin
    last_d  = last_q;
    owner_d = owner_q;
    lock_d  = 1'b0;
    cnt_d   = '0;
    raddr_d = rd_grant ? win_addr : raddr_q;
    tag1_d  = '{valid: rd_grant, port: win};
    if (grant) begin
      last_d  = win;
      owner_d = win;
      lock_d  = win_lock;
      if ((win == owner_q) && lock_q) cnt_d = (cnt_q == MAX_CNT) ? cnt_q : cnt_q + 1'b1;
      else                            cnt_d = CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      lock_q  <= 1'b0;
      cnt_q   <= '0;
      raddr_q <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
    end else begin
      // NOTE: non-blocking so tag2_q takes the pre-edge tag1_q, forming a real pipeline.
      last_q  <= last_d;
      owner_q <= owner_d;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      raddr_q <= raddr_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag1_q;
    end
  end

  assign c0_rvalid = tag2_q.valid & ~tag2_q.port;
  assign c1_rvalid = tag2_q.valid &  tag2_q.port;
  assign c0_rdata  = c0_rvalid ? mem_rdata : '0;
  assign c1_rdata  = c1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a 2-cycle memory device, a rule-level reference
// model checked every cycle, and literal expectations from the test plan.
module tb_mem_arbiter;

  localparam int MAX_BURST = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       c0_req, c1_req, c0_we, c1_we, c0_lock, c1_lock;
  logic [7:0] c0_addr, c1_addr, c0_wdata, c1_wdata;
  logic       c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
  logic [7:0] c0_rdata, c1_rdata, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic       mem_we;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c1_req(c1_req), .c0_we(c0_we), .c1_we(c1_we),
    .c0_lock(c0_lock), .c1_lock(c1_lock), .c0_addr(c0_addr), .c1_addr(c1_addr),
    .c0_wdata(c0_wdata), .c1_wdata(c1_wdata), .c0_gnt(c0_gnt), .c1_gnt(c1_gnt),
    .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid), .c0_rdata(c0_rdata), .c1_rdata(c1_rdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_we(mem_we),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  // Memory device: write at end of cycle, read address registered then data registered.
  logic [7:0] mem [256];
  logic [7:0] s1, s2;
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    s1 <= mem[mem_raddr];
    s2 <= s1;
  end
  assign mem_rdata = s2;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: rules applied to an unbounded streak count and a queue of pending reads.
  typedef struct {
    int         due;
    bit         port;
    logic [7:0] data;
  } rd_t;

  logic [7:0] mmem [256];
  rd_t        pend [$];
  bit         m_last, m_prev_locked, m_any, m_w, m_we, m_v0, m_v1;
  int         m_streak;
  logic [7:0] m_raddr, m_addr, m_wd, m_d0, m_d1;

  always @(negedge clk) begin
    if (reset) begin
      m_last = 1'b1; m_prev_locked = 1'b0; m_streak = 0; m_raddr = 8'h00;
      pend.delete();
      check("rst_gnt", {c0_gnt, c1_gnt}, 2'b00);
      check("rst_rvalid", {c0_rvalid, c1_rvalid}, 2'b00);
      check("rst_rdata", {c0_rdata, c1_rdata}, 16'h0);
      check("rst_we", {mem_we, mem_waddr, mem_wdata}, 17'h0);
      check("rst_raddr", mem_raddr, 8'h00);
    end else begin
      m_any = c0_req | c1_req;
      if (c0_req != c1_req)                               m_w = c1_req;
      else if (m_prev_locked && m_streak < MAX_BURST)     m_w = m_last;
      else                                                m_w = !m_last;
      m_we   = m_w ? c1_we : c0_we;
      m_addr = m_w ? c1_addr : c0_addr;
      m_wd   = m_w ? c1_wdata : c0_wdata;
      check("gnt", {c0_gnt, c1_gnt}, m_any ? (m_w ? 2'b01 : 2'b10) : 2'b00);
      check("mem_we", mem_we, m_any && m_we);
      if (m_any && m_we) check("mem_write", {mem_waddr, mem_wdata}, {m_addr, m_wd});
      if (m_any && !m_we) m_raddr = m_addr;
      check("mem_raddr", mem_raddr, m_raddr);

      m_v0 = 0; m_v1 = 0; m_d0 = 0; m_d1 = 0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        if (pend[0].port) begin m_v1 = 1; m_d1 = pend[0].data; end
        else              begin m_v0 = 1; m_d0 = pend[0].data; end
        void'(pend.pop_front());
      end
      check("rvalid", {c0_rvalid, c1_rvalid}, {m_v0, m_v1});
      check("rdata", {c0_rdata, c1_rdata}, {m_d0, m_d1});

      if (m_any) begin
        if (m_we) mmem[m_addr] = m_wd;
        else      pend.push_back('{due: cyc + 2, port: m_w, data: mmem[m_addr]});
        m_streak      = (m_w == m_last && m_prev_locked) ? m_streak + 1 : 1;
        m_last        = m_w;
        m_prev_locked = m_w ? c1_lock : c0_lock;
      end else begin
        m_prev_locked = 1'b0;
        m_streak      = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    c0_req = 0; c1_req = 0; c0_we = 0; c1_we = 0; c0_lock = 0; c1_lock = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'(i) ^ 8'h5A;
      mmem[i] = 8'(i) ^ 8'h5A;
    end
    mem[8'h10] = 8'hA5; mmem[8'h10] = 8'hA5;
    c0_addr = 0; c1_addr = 0; c0_wdata = 0; c1_wdata = 0;
    idle();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;

    // Single read by c0 from 0x10.
    c0_req = 1; c0_addr = 8'h10;
    mid(); check("t1_gnt", {c0_gnt, c1_gnt}, 2'b10);
    tick(); idle();
    mid(); check("t1_no_early", c0_rvalid, 1'b0);
    tick();
    mid(); check("t1_rvalid", {c0_rvalid, c1_rvalid}, 2'b10);
    check("t1_rdata", c0_rdata, 8'hA5);
    tick();

    // Both reading, no lock: alternate, starting with c1 since c0 was last.
    c0_req = 1; c0_addr = 8'h30; c1_req = 1; c1_addr = 8'h40;
    for (int i = 0; i < 8; i++) begin
      mid(); check("t2_alt", {c0_gnt, c1_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    idle(); repeat (3) tick();

    // Write by c1 then read by c0 of the same address returns the new value.
    c1_req = 1; c1_we = 1; c1_addr = 8'h20; c1_wdata = 8'h3C;
    mid(); check("t3_write", {mem_we, mem_waddr, mem_wdata}, {1'b1, 8'h20, 8'h3C});
    tick(); idle(); c0_req = 1; c0_addr = 8'h20;
    mid(); check("t3_rd_gnt", c0_gnt, 1'b1);
    tick(); idle();
    mid(); tick();
    mid(); check("t3_new", {c0_rvalid, c0_rdata}, {1'b1, 8'h3C});
    tick();

    // Read then write of the same address returns the old value.
    c0_req = 1; c0_addr = 8'h50;
    mid(); tick(); idle();
    c1_req = 1; c1_we = 1; c1_addr = 8'h50; c1_wdata = 8'hEE;
    mid(); tick(); idle();
    mid(); check("t3_old", {c0_rvalid, c0_rdata}, {1'b1, 8'h0A});
    tick(); repeat (2) tick();

    // c1 locking against a continuous c0: c0, then c1 x4, repeating.
    c0_req = 1; c0_addr = 8'h70; c1_req = 1; c1_lock = 1; c1_addr = 8'h60;
    for (int i = 0; i < 15; i++) begin
      mid(); check("t4_burst", {c0_gnt, c1_gnt}, (i % 5 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    idle(); repeat (3) tick();

    // c0 locks with c1 idle for 10 cycles; c1 wins its first request cycle.
    c0_req = 1; c0_lock = 1; c0_addr = 8'h11;
    repeat (10) begin mid(); tick(); end
    c1_req = 1; c1_addr = 8'h12;
    mid(); check("t5_yield", {c0_gnt, c1_gnt}, 2'b01);
    tick(); mid(); tick();
    idle(); repeat (3) tick();

    // Reset with two reads in flight drops both; first tie afterwards goes to c0.
    c0_req = 1; c0_addr = 8'h21;
    mid(); tick(); idle(); c1_req = 1; c1_addr = 8'h22;
    mid(); tick(); idle(); reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid(); check("t6_dropped", {c0_rvalid, c1_rvalid}, 2'b00);
      tick();
    end
    c0_req = 1; c0_addr = 8'h23; c1_req = 1; c1_addr = 8'h24;
    mid(); check("t6_tie", {c0_gnt, c1_gnt}, 2'b10);
    tick(); idle();
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
